// File: rtl/lsu_sequencer_if.sv
// Bundle of the core, serialiser and memory-handshake signals around the load/store sequencer.
// master = core/serialiser/memory side, slave = the sequencer itself.
interface lsu_sequencer_if;
  logic       start;
  logic       is_store;
  logic [2:0] func;
  logic       addr_bit;
  logic       mem_misaligned;
  logic       mem_ack;
  logic [4:0] bit_pos;
  logic       ser_mode;
  logic       bit_valid;
  logic       mem_req;
  logic       mem_we;
  logic [3:0] mem_be;
  logic       busy;
  logic       done;
  logic       trap_misaligned;
  logic       bus_error;

  modport master (
    output start, is_store, func, addr_bit, mem_misaligned, mem_ack,
    input  bit_pos, ser_mode, bit_valid, mem_req, mem_we, mem_be,
           busy, done, trap_misaligned, bus_error
  );

  modport slave (
    input  start, is_store, func, addr_bit, mem_misaligned, mem_ack,
    output bit_pos, ser_mode, bit_valid, mem_req, mem_we, mem_be,
           busy, done, trap_misaligned, bus_error
  );
endinterface

// File: rtl/lsu_sequencer.sv
// Load/store sequencer: shifts in the serial address, issues one word-wide memory request
// and drives the bit-serial data phase, reporting done / misaligned trap / bus timeout.
module lsu_sequencer #(
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned TIMEOUT   = 15
) (
  input logic           clk,
  input logic           reset,
  lsu_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, CHECK, SHIFT_W, REQ, SHIFT_R
  } state_e;

  localparam logic [4:0] ADDR_LAST = 5'(ADDR_BITS - 1);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT);

  state_e     state_q;
  logic [4:0] bit_pos_q;
  logic [7:0] wait_q;
  logic       ser_mode_q, bit_valid_q;
  logic       mem_req_q, mem_we_q;
  logic [3:0] mem_be_q;
  logic       busy_q, done_q, trap_q, bus_error_q;
  logic       is_store_q;
  logic [1:0] size_q;
  logic       a0_q, a1_q;

  logic [3:0] mem_be_d;
  logic [4:0] shift_last;

  // Sign/zero fill of loads is done in the serialiser, so the unsigned flag is not needed here.
  logic unused_func_sign;
  assign unused_func_sign = bus.func[2];

  always_comb begin
    mem_be_d   = 4'b1111;
    shift_last = 5'd31;
    unique case (size_q)
      2'b00: begin
        mem_be_d   = 4'b0001 << {a1_q, a0_q};
        shift_last = 5'd7;
      end
      2'b01: begin
        mem_be_d   = a1_q ? 4'b1100 : 4'b0011;
        shift_last = 5'd15;
      end
      default: ;
    endcase
  end

  // NOTE: every register here is state, so only non-blocking assignments are used; the three
  // status pulses default low each cycle and are raised only on the edge that ends an access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_pos_q   <= '0;
      wait_q      <= '0;
      ser_mode_q  <= 1'b0;
      bit_valid_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      trap_q      <= 1'b0;
      bus_error_q <= 1'b0;
      is_store_q  <= 1'b0;
      size_q      <= '0;
      a0_q        <= 1'b0;
      a1_q        <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      trap_q      <= 1'b0;
      bus_error_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= ADDR;
            busy_q     <= 1'b1;
            ser_mode_q <= 1'b1;
            bit_pos_q  <= '0;
            is_store_q <= bus.is_store;
            size_q     <= bus.func[1:0];
          end
        end
        ADDR: begin
          if (bit_pos_q == 5'd0) a0_q <= bus.addr_bit;
          if (bit_pos_q == 5'd1) a1_q <= bus.addr_bit;
          if (bit_pos_q == ADDR_LAST) state_q   <= CHECK;
          else                        bit_pos_q <= bit_pos_q + 5'd1;
        end
        CHECK: begin
          ser_mode_q <= 1'b0;
          bit_pos_q  <= '0;
          if (bus.mem_misaligned) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            trap_q  <= 1'b1;
          end else if (is_store_q) begin
            state_q     <= SHIFT_W;
            bit_valid_q <= 1'b1;
          end else begin
            state_q   <= REQ;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b0;
            mem_be_q  <= mem_be_d;
            wait_q    <= '0;
          end
        end
        SHIFT_W: begin
          if (bit_pos_q == shift_last) begin
            state_q     <= REQ;
            bit_valid_q <= 1'b0;
            bit_pos_q   <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_be_q    <= mem_be_d;
            wait_q      <= '0;
          end else begin
            bit_pos_q <= bit_pos_q + 5'd1;
          end
        end
        REQ: begin
          // An ack on the same cycle the counter reaches the limit still completes the access.
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_be_q  <= '0;
            if (is_store_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q     <= SHIFT_R;
              bit_valid_q <= 1'b1;
              bit_pos_q   <= '0;
            end
          end else if (wait_q == WAIT_LAST) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            bus_error_q <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        SHIFT_R: begin
          if (bit_pos_q == 5'd31) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            bit_valid_q <= 1'b0;
            bit_pos_q   <= '0;
          end else begin
            bit_pos_q <= bit_pos_q + 5'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.bit_pos         = bit_pos_q;
  assign bus.ser_mode        = ser_mode_q;
  assign bus.bit_valid       = bit_valid_q;
  assign bus.mem_req         = mem_req_q;
  assign bus.mem_we          = mem_we_q;
  assign bus.mem_be          = mem_be_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.trap_misaligned = trap_q;
  assign bus.bus_error       = bus_error_q;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer: expected request attributes and outcomes are queued when an
// access is launched and checked by a negedge monitor when the sequencer produces them.
module tb_lsu_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lsu_sequencer_if bus ();

  lsu_sequencer #(.ADDR_BITS(12), .TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       we;
    logic [3:0] be;
  } req_t;

  localparam logic [2:0] OUT_DONE = 3'b100;
  localparam logic [2:0] OUT_TRAP = 3'b010;
  localparam logic [2:0] OUT_BERR = 3'b001;

  req_t       req_q[$];
  logic [2:0] out_q[$];

  int   n_cmp = 0;
  int   n_err = 0;
  int   bv_total, bv_idx, req_cycles, busy_cycles;
  bit   out_seen;
  logic req_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [16:0] all_outs();
    return {bus.bit_pos, bus.ser_mode, bus.bit_valid, bus.mem_req, bus.mem_we, bus.mem_be,
            bus.busy, bus.done, bus.trap_misaligned, bus.bus_error};
  endfunction

  // Monitor: bit_pos sequencing during data phases, request attributes, outcome pulses.
  always @(negedge clk) begin
    req_t e;
    if (reset) begin
      bv_idx = 0;
    end else begin
      if (bus.busy)    busy_cycles++;
      if (bus.mem_req) req_cycles++;
      if (bus.bit_valid) begin
        check("data_bit_pos", {27'd0, bus.bit_pos}, bv_idx);
        check("data_ser_mode", {31'd0, bus.ser_mode}, 32'd0);
        bv_idx++;
        bv_total++;
      end else begin
        bv_idx = 0;
      end
      if (bus.mem_req && !req_prev) begin
        if (req_q.size() == 0) begin
          check("unexpected_req", {31'd0, bus.mem_req}, 32'd0);
        end else begin
          e = req_q.pop_front();
          check("mem_we", {31'd0, bus.mem_we}, {31'd0, e.we});
          check("mem_be", {28'd0, bus.mem_be}, {28'd0, e.be});
        end
      end
      if (bus.done || bus.trap_misaligned || bus.bus_error) begin
        out_seen = 1'b1;
        if (out_q.size() == 0)
          check("unexpected_outcome", {29'd0, bus.done, bus.trap_misaligned, bus.bus_error}, 32'd0);
        else
          check("outcome", {29'd0, bus.done, bus.trap_misaligned, bus.bus_error},
                {29'd0, out_q.pop_front()});
      end
    end
    req_prev = bus.mem_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch an access and feed the 12 address bits plus the misalign flag in CHECK.
  task automatic begin_access(input logic st, input logic [2:0] fn, input logic [11:0] addr,
                              input logic misal);
    bv_total    = 0;
    req_cycles  = 0;
    busy_cycles = 0;
    out_seen    = 1'b0;
    bus.start    = 1'b1;
    bus.is_store = st;
    bus.func     = fn;
    tick();
    bus.start    = 1'b0;
    bus.is_store = ~st;        // captured values must be held internally
    bus.func     = ~fn;
    check("addr_ser_mode", {31'd0, bus.ser_mode}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      bus.addr_bit = addr[i];
      check("addr_bit_pos", {27'd0, bus.bit_pos}, i);
      tick();
    end
    bus.addr_bit = 1'b0;
    check("check_bit_pos", {27'd0, bus.bit_pos}, 32'd11);
    check("check_ser_mode", {31'd0, bus.ser_mode}, 32'd1);
    bus.mem_misaligned = misal;
    tick();
    bus.mem_misaligned = 1'b0;
  endtask

  task automatic wait_req();
    for (int k = 0; k < 64 && !bus.mem_req; k++) tick();
    check("req_seen", {31'd0, bus.mem_req}, 32'd1);
  endtask

  task automatic give_ack(input int n);
    repeat (n) tick();
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
  endtask

  task automatic wait_outcome();
    for (int k = 0; k < 100 && !out_seen; k++) tick();
    check("outcome_seen", {31'd0, out_seen}, 32'd1);
    check("busy_after", {31'd0, bus.busy}, 32'd0);
    check("pulse_single", {29'd0, bus.done, bus.trap_misaligned, bus.bus_error}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset              = 1'b1;
    bus.start          = 1'b0;
    bus.is_store       = 1'b0;
    bus.func           = 3'b000;
    bus.addr_bit       = 1'b0;
    bus.mem_misaligned = 1'b0;
    bus.mem_ack        = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {15'd0, all_outs()}, 32'd0);
    reset = 1'b0;
    tick();
    check("idle_outputs", {15'd0, all_outs()}, 32'd0);

    // 1: load word @0x010, ack 3 cycles after mem_req
    req_q.push_back({1'b0, exp_be(2'b10, 2'b00)});
    out_q.push_back(OUT_DONE);
    begin_access(1'b0, 3'b010, 12'h010, 1'b0);
    wait_req();
    give_ack(3);
    wait_outcome();
    check("t1_read_bits", bv_total, 32'd32);
    check("t1_req_cycles", req_cycles, 32'd4);
    check("t1_latency", busy_cycles, 32'd49);

    // 2: store byte @0x013, 8 data bits before the request
    req_q.push_back({1'b1, exp_be(2'b00, 2'b11)});
    out_q.push_back(OUT_DONE);
    begin_access(1'b1, 3'b000, 12'h013, 1'b0);
    wait_req();
    check("t2_bits_before_req", bv_total, 32'd8);
    give_ack(2);
    wait_outcome();
    check("t2_total_bits", bv_total, 32'd8);
    check("t2_latency", busy_cycles, 32'd24);

    // 3: store half @0x011 flagged misaligned -> trap, no request
    out_q.push_back(OUT_TRAP);
    begin_access(1'b1, 3'b001, 12'h011, 1'b1);
    wait_outcome();
    check("t3_no_req", req_cycles, 32'd0);
    check("t3_no_bits", bv_total, 32'd0);
    check("t3_latency", busy_cycles, 32'd13);

    // 4: load half @0x002, no ack -> bus error after 16 request cycles; late ack ignored
    req_q.push_back({1'b0, exp_be(2'b01, 2'b10)});
    out_q.push_back(OUT_BERR);
    begin_access(1'b0, 3'b001, 12'h002, 1'b0);
    wait_req();
    wait_outcome();
    check("t4_req_cycles", req_cycles, 32'd16);
    check("t4_latency", busy_cycles, 32'd29);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    tick();
    check("t4_late_ack_req", {31'd0, bus.mem_req}, 32'd0);
    check("t4_late_ack_busy", {31'd0, bus.busy}, 32'd0);

    // 5a: start pulsed during SHIFT_R is ignored
    req_q.push_back({1'b0, exp_be(2'b10, 2'b00)});
    out_q.push_back(OUT_DONE);
    begin_access(1'b0, 3'b010, 12'h008, 1'b0);
    wait_req();
    give_ack(0);
    repeat (5) tick();
    bus.start    = 1'b1;
    bus.is_store = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_outcome();
    check("t5_read_bits", bv_total, 32'd32);
    check("t5_latency", busy_cycles, 32'd46);
    repeat (20) tick();
    check("t5_stays_idle", {31'd0, bus.busy}, 32'd0);

    // 5b: reset mid-REQ, then a clean store word
    req_q.push_back({1'b0, exp_be(2'b10, 2'b00)});
    begin_access(1'b0, 3'b010, 12'h004, 1'b0);
    wait_req();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("midreq_reset_outputs", {15'd0, all_outs()}, 32'd0);
    reset = 1'b0;
    repeat (5) tick();
    check("midreq_no_pulse", {31'd0, out_seen}, 32'd0);
    check("midreq_idle", {15'd0, all_outs()}, 32'd0);

    req_q.push_back({1'b1, exp_be(2'b10, 2'b00)});
    out_q.push_back(OUT_DONE);
    begin_access(1'b1, 3'b010, 12'h004, 1'b0);
    wait_req();
    check("t5_store_bits", bv_total, 32'd32);
    give_ack(1);
    wait_outcome();
    check("t5_store_latency", busy_cycles, 32'd47);

    check("req_queue_empty", req_q.size(), 32'd0);
    check("out_queue_empty", out_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
